// File: rtl/rv32v_types_pkg.sv
// Shared vector-pipeline types: element width, element offset type and the
// micro-op sequencer state encoding.
package rv32v_types_pkg;

   // Element index width; vl/vstart carry one extra bit so 0..2**VL_WIDTH fits.
   localparam int VL_WIDTH = 7;

   // Element offset presented to a single execute lane.
   typedef logic [VL_WIDTH-1:0] offset_t;

   // Element count / index with room for the full vector length.
   typedef logic [VL_WIDTH:0] count_t;

   // Micro-op sequencer control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ZDONE = 2'd2
   } uopseq_state_t;

endpackage : rv32v_types_pkg

// File: rtl/rv32v_uop_sequencer.sv
// Vector micro-op sequencer: turns one accepted vector instruction into a
// stream of two-lane element uops (offsets + lane enables) for execute,
// holding the current uop while execute stalls.
module rv32v_uop_sequencer #(
   parameter int VL_WIDTH = rv32v_types_pkg::VL_WIDTH
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [VL_WIDTH:0]   vl,
   input  logic [VL_WIDTH:0]   vstart,
   input  logic                stall,
   input  logic                flush,
   output logic                uop_valid,
   output logic [VL_WIDTH-1:0] woffset0,
   output logic [VL_WIDTH-1:0] woffset1,
   output logic                wen0,
   output logic                wen1,
   output logic                first_uop,
   output logic                last_uop,
   output logic                busy,
   output logic                done
);

   // Width of element counts (vl, vstart, idx) and of the non-wrapping sum.
   localparam int CW = VL_WIDTH + 1;
   localparam int SW = VL_WIDTH + 2;

   rv32v_types_pkg::uopseq_state_t state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [CW-1:0] vl_q, vl_d;
   logic [CW-1:0] vstart_q, vstart_d;
   logic          done_q, done_d;

   // Derived per-uop values, all from registered state only.
   logic          issuing;
   logic [CW-1:0] idx_p1;
   logic [SW-1:0] idx_p2;
   logic          lane1_in_body;
   logic          is_last;

   assign issuing       = (state_q == rv32v_types_pkg::ISSUE);
   // idx < vl <= 2**VL_WIDTH while issuing, so idx+1 fits in CW bits.
   assign idx_p1        = idx_q + CW'(1);
   // Widened so that idx+2 never wraps when vl is the maximum length.
   assign idx_p2        = {1'b0, idx_q} + SW'(2);
   assign lane1_in_body = (idx_p1 < vl_q);
   assign is_last       = (idx_p2 >= {1'b0, vl_q});

   // Next-state and counter update: accept, consume, stall-hold, flush abort.
   always_comb begin
      // NOTE: every signal written here gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      idx_d    = idx_q;
      vl_d     = vl_q;
      vstart_d = vstart_q;
      done_d   = 1'b0;

      unique case (state_q)
         rv32v_types_pkg::IDLE: begin
            // Flush outranks a concurrent accept; the instruction is dropped.
            if (!flush && instr_valid) begin
               vl_d     = vl;
               vstart_d = vstart;
               idx_d    = vstart;
               state_d  = (vstart >= vl) ? rv32v_types_pkg::ZDONE
                                         : rv32v_types_pkg::ISSUE;
            end
         end

         rv32v_types_pkg::ISSUE: begin
            if (flush) begin
               state_d = rv32v_types_pkg::IDLE;
            end else if (!stall) begin
               if (is_last) begin
                  state_d = rv32v_types_pkg::IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + CW'(2);
               end
            end
         end

         rv32v_types_pkg::ZDONE: begin
            // Done is decoded from this state; a flush here changes nothing.
            state_d = rv32v_types_pkg::IDLE;
         end

         default: begin
            state_d = rv32v_types_pkg::IDLE;
         end
      endcase
   end

   // State, counter and done registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge nRST) begin
      // NOTE: the latched vl/vstart are reset too, not just the state, so the
      // block powers up in a fully defined condition.
      if (!nRST) begin
         state_q  <= rv32v_types_pkg::IDLE;
         idx_q    <= '0;
         vl_q     <= '0;
         vstart_q <= '0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed by the combinational process.
         state_q  <= state_d;
         idx_q    <= idx_d;
         vl_q     <= vl_d;
         vstart_q <= vstart_d;
         done_q   <= done_d;
      end
   end

   // Outputs: decoded from registers; uop fields are zero outside ISSUE.
   always_comb begin
      instr_ready = (state_q == rv32v_types_pkg::IDLE);
      busy        = (state_q != rv32v_types_pkg::IDLE);
      uop_valid   = issuing;
      done        = done_q || (state_q == rv32v_types_pkg::ZDONE);
      woffset0    = issuing ? idx_q[VL_WIDTH-1:0]  : '0;
      woffset1    = issuing ? idx_p1[VL_WIDTH-1:0] : '0;
      wen0        = issuing;
      wen1        = issuing && lane1_in_body;
      first_uop   = issuing && (idx_q == vstart_q);
      last_uop    = issuing && is_last;
   end

endmodule : rv32v_uop_sequencer

// File: tb/tb_rv32v_uop_sequencer.sv
// Directed self-checking bench for rv32v_uop_sequencer. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
module tb_rv32v_uop_sequencer;

   localparam int W = 7;

   logic         CLK;
   logic         nRST;
   logic         instr_valid;
   logic         instr_ready;
   logic [W:0]   vl;
   logic [W:0]   vstart;
   logic         stall;
   logic         flush;
   logic         uop_valid;
   logic [W-1:0] woffset0;
   logic [W-1:0] woffset1;
   logic         wen0;
   logic         wen1;
   logic         first_uop;
   logic         last_uop;
   logic         busy;
   logic         done;

   int checks   = 0;
   int failures = 0;

   rv32v_uop_sequencer #(.VL_WIDTH(W)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .vl          (vl),
      .vstart      (vstart),
      .stall       (stall),
      .flush       (flush),
      .uop_valid   (uop_valid),
      .woffset0    (woffset0),
      .woffset1    (woffset1),
      .wen0        (wen0),
      .wen1        (wen1),
      .first_uop   (first_uop),
      .last_uop    (last_uop),
      .busy        (busy),
      .done        (done)
   );

   // 10-unit clock.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full uop check: valid, offsets, enables, first/last.
   task automatic check_uop(input string tag, input logic [W-1:0] o0, input logic [W-1:0] o1,
                            input logic w1, input logic f, input logic l);
      check({tag, ".uop_valid"}, 32'(uop_valid), 32'd1);
      check({tag, ".woffset0"},  32'(woffset0),  32'(o0));
      check({tag, ".woffset1"},  32'(woffset1),  32'(o1));
      check({tag, ".wen0"},      32'(wen0),      32'd1);
      check({tag, ".wen1"},      32'(wen1),      32'(w1));
      check({tag, ".first_uop"}, 32'(first_uop), 32'(f));
      check({tag, ".last_uop"},  32'(last_uop),  32'(l));
      check({tag, ".busy"},      32'(busy),      32'd1);
      check({tag, ".ready"},     32'(instr_ready), 32'd0);
      check({tag, ".done"},      32'(done),      32'd0);
   endtask

   // Idle/reset-value check with an expected done level.
   task automatic check_idle(input string tag, input logic d);
      check({tag, ".ready"},     32'(instr_ready), 32'd1);
      check({tag, ".uop_valid"}, 32'(uop_valid),   32'd0);
      check({tag, ".busy"},      32'(busy),        32'd0);
      check({tag, ".done"},      32'(done),        32'(d));
      check({tag, ".woffset0"},  32'(woffset0),    32'd0);
      check({tag, ".woffset1"},  32'(woffset1),    32'd0);
      check({tag, ".wen"},       32'({wen0, wen1, first_uop, last_uop}), 32'd0);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic present(input logic [W:0] l, input logic [W:0] s);
      instr_valid = 1'b1;
      vl          = l;
      vstart      = s;
   endtask

   initial begin
      nRST = 1'b0; instr_valid = 1'b0; vl = '0; vstart = '0; stall = 1'b0; flush = 1'b0;

      // Reset values.
      #12;
      check_idle("reset", 1'b0);
      tick();
      nRST = 1'b1;
      tick();
      check_idle("post_reset", 1'b0);

      // vl=5, vstart=0: (0,1) (2,3) (4,5 wen1=0 last).
      present(8'd5, 8'd0);
      tick();
      instr_valid = 1'b0;
      check_uop("vl5.u0", 7'd0, 7'd1, 1'b1, 1'b1, 1'b0);
      tick();
      check_uop("vl5.u1", 7'd2, 7'd3, 1'b1, 1'b0, 1'b0);
      tick();
      check_uop("vl5.u2", 7'd4, 7'd5, 1'b0, 1'b0, 1'b1);
      tick();
      check_idle("vl5.done", 1'b1);

      // vl=8, vstart=3 accepted in the same cycle done is high.
      present(8'd8, 8'd3);
      tick();
      instr_valid = 1'b0;
      check_uop("vl8.u0", 7'd3, 7'd4, 1'b1, 1'b1, 1'b0);
      tick();
      check_uop("vl8.u1", 7'd5, 7'd6, 1'b1, 1'b0, 1'b0);
      tick();
      check_uop("vl8.u2", 7'd7, 7'd8, 1'b0, 1'b0, 1'b1);
      tick();
      check_idle("vl8.done", 1'b1);
      tick();
      check_idle("vl8.after", 1'b0);

      // vl=0: zero-length, done at k+1, ready low only then.
      present(8'd0, 8'd0);
      tick();
      instr_valid = 1'b0;
      check("vl0.done",  32'(done),        32'd1);
      check("vl0.ready", 32'(instr_ready), 32'd0);
      check("vl0.valid", 32'(uop_valid),   32'd0);
      check("vl0.busy",  32'(busy),        32'd1);
      tick();
      check_idle("vl0.k2", 1'b0);

      // vstart=9 >= vl=4: zero-length as well.
      present(8'd4, 8'd9);
      tick();
      instr_valid = 1'b0;
      check("vs9.done",  32'(done),        32'd1);
      check("vs9.ready", 32'(instr_ready), 32'd0);
      check("vs9.valid", 32'(uop_valid),   32'd0);
      tick();
      check_idle("vs9.k2", 1'b0);

      // vl=6 with 3 stall cycles on the second uop.
      present(8'd6, 8'd0);
      tick();
      instr_valid = 1'b0;
      check_uop("vl6.u0", 7'd0, 7'd1, 1'b1, 1'b1, 1'b0);
      tick();
      check_uop("vl6.u1", 7'd2, 7'd3, 1'b1, 1'b0, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_uop($sformatf("vl6.hold%0d", i), 7'd2, 7'd3, 1'b1, 1'b0, 1'b0);
      end
      stall = 1'b0;
      tick();
      check_uop("vl6.u2", 7'd4, 7'd5, 1'b1, 1'b0, 1'b1);
      tick();
      check_idle("vl6.done", 1'b1);
      tick();
      check_idle("vl6.after", 1'b0);

      // vl=10: flush together with stall on the second uop.
      present(8'd10, 8'd0);
      tick();
      instr_valid = 1'b0;
      check_uop("vl10.u0", 7'd0, 7'd1, 1'b1, 1'b1, 1'b0);
      tick();
      check_uop("vl10.u1", 7'd2, 7'd3, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      stall = 1'b1;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      check_idle("vl10.flush", 1'b0);
      present(8'd2, 8'd0);
      tick();
      instr_valid = 1'b0;
      check_uop("flush.next", 7'd0, 7'd1, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("flush.next.done", 1'b1);
      tick();

      // vl=128, vstart=126: single uop at the top of the index range.
      present(8'd128, 8'd126);
      tick();
      instr_valid = 1'b0;
      check_uop("vl128.top", 7'd126, 7'd127, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("vl128.top.done", 1'b1);
      tick();

      // vl=128 from 0, asynchronous reset mid-instruction.
      present(8'd128, 8'd0);
      tick();
      instr_valid = 1'b0;
      check_uop("rst.u0", 7'd0, 7'd1, 1'b1, 1'b1, 1'b0);
      tick();
      check_uop("rst.u1", 7'd2, 7'd3, 1'b1, 1'b0, 1'b0);
      #2;
      nRST = 1'b0;
      #1;
      check_idle("rst.async", 1'b0);
      tick();
      check_idle("rst.held", 1'b0);
      nRST = 1'b1;
      tick();
      check_idle("rst.release", 1'b0);
      present(8'd2, 8'd0);
      tick();
      instr_valid = 1'b0;
      check_uop("rst.vl2", 7'd0, 7'd1, 1'b1, 1'b1, 1'b1);
      tick();
      check_idle("rst.vl2.done", 1'b1);
      tick();
      check_idle("rst.vl2.after", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rv32v_uop_sequencer
